// File: rtl/apb4_mst_bridge.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS on APB4, valid/ready response out.
// Optional ACCESS-phase timeout abort is enabled by defining APB4_MST_TIMEOUT_EN.
module apb4_mst_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [3:0]            req_strb_i,
  input  logic [2:0]            req_prot_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [3:0]            pstrb_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("apb4_mst_bridge: DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("apb4_mst_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                state_q;
  logic                  req_ready_q;
  logic                  psel_q;
  logic                  penable_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [3:0]            pstrb_q;
  logic [3:0]            pstrb_d;
  logic [2:0]            pprot_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  // Reads never carry byte strobes onto the bus.
  assign pstrb_d = req_write_i ? req_strb_i : 4'h0;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_tmo_q;
  assign rsp_timeout_o = rsp_tmo_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_tmo_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_ready_q && req_valid_i) begin
            paddr_q     <= req_addr_i;
            pwrite_q    <= req_write_i;
            pwdata_q    <= req_wdata_i;
            pstrb_q     <= pstrb_d;
            pprot_q     <= req_prot_i;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end else begin
            // Ready comes up one cycle after reset release.
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB4_MST_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          if (pready_i) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
            rsp_err_q   <= pslverr_i;
`ifdef APB4_MST_TIMEOUT_EN
            rsp_tmo_q   <= 1'b0;
`endif
            state_q     <= RESP;
          end
`ifdef APB4_MST_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign pprot_o     = pprot_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
